// File: rtl/isa_pkg.sv
// isa_pkg: instruction classes, sub-op and flag codes, and opcode prefixes
// shared by the encoder, the loader and the testbench.
package isa_pkg;
    localparam int IW = 9;
    typedef enum logic [2:0] {
        CLS_MOV, CLS_B, CLS_LI, CLS_SHIFT, CLS_MEM, CLS_SBF, CLS_ALU, CLS_ILL
    } instr_class_e;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT, ALU_XOR} alu_op_e;
    typedef enum logic [2:0] {FLG_NE, FLG_EQ, FLG_LT, FLG_LE, FLG_JP} flag_e;
    localparam logic [0:0] PFX_MOV   = 1'b0;
    localparam logic [2:0] PFX_B     = 3'b100;
    localparam logic [2:0] PFX_LI    = 3'b101;
    localparam logic [2:0] PFX_SHIFT = 3'b110;
    localparam logic [3:0] PFX_ALU   = 4'b1110;
    localparam logic [4:0] PFX_MEM   = 5'b11110;
    localparam logic [5:0] PFX_SBF   = 6'b111011;
    typedef struct packed {
        instr_class_e cls;
        logic [3:0]   dst;
        logic [3:0]   src;
        logic [5:0]   imm;
        logic [2:0]   sub;
    } desc_t;
endpackage

// File: rtl/instr_encoder.sv
// instr_encoder: combinational descriptor to 9-bit machine word, flagging
// encodings that the decoder cannot represent.
module instr_encoder
    import isa_pkg::*;
(
    input  desc_t         desc_i,
    output logic [IW-1:0] word_o,
    output logic          illegal_o
);
    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (desc_i.cls)
            CLS_MOV:   word_o = {PFX_MOV, desc_i.dst, desc_i.src};
            CLS_B:     word_o = {PFX_B, desc_i.imm};
            CLS_LI:    word_o = {PFX_LI, desc_i.imm};
            CLS_SHIFT: word_o = {PFX_SHIFT, desc_i.sub[0], desc_i.dst[1:0], desc_i.imm[2:0]};
            CLS_MEM:   word_o = {PFX_MEM, desc_i.sub[0], desc_i.src[2:0]};
            CLS_SBF: begin
                word_o    = {PFX_SBF, desc_i.sub};
                illegal_o = desc_i.sub > FLG_JP;
            end
            CLS_ALU: begin
                word_o    = {PFX_ALU, desc_i.sub, desc_i.dst[1:0]};
                illegal_o = desc_i.sub > ALU_XOR;
            end
            default:   illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes a stream of instruction descriptors and writes
// them to consecutive instruction-memory addresses through a registered port.
module instr_encoder_loader #(
    parameter int AW = 10,
    parameter int IW = 9
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_class,
    input  logic [3:0]    in_dst,
    input  logic [3:0]    in_src,
    input  logic [5:0]    in_imm,
    input  logic [2:0]    in_sub,
    input  logic          in_last,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [IW-1:0] im_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] err_addr,
    output logic [AW:0]   count
);
    import isa_pkg::*;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAULT} state_e;
    localparam logic [AW-1:0] ADDR_MAX = '1;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, waddr_q, waddr_d, err_addr_q, err_addr_d;
    logic [AW:0]   count_q, count_d;
    logic [IW-1:0] wdata_q, wdata_d, enc_word;
    logic          we_q, we_d, done_q, done_d, err_q, err_d;
    logic          enc_illegal, accept, ovf;
    desc_t         desc;

    assign desc = '{cls: instr_class_e'(in_class), dst: in_dst, src: in_src, imm: in_imm, sub: in_sub};

    instr_encoder u_enc (
        .desc_i   (desc),
        .word_o   (enc_word),
        .illegal_o(enc_illegal)
    );

    assign in_ready = state_q == S_RUN;
    assign accept   = in_valid && in_ready;
    // the top address can still be written, but only a last word may end there
    assign ovf      = !in_last && addr_q == ADDR_MAX;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (start && state_q != S_RUN) begin
            state_d    = S_RUN;
            addr_d     = base_addr;
            count_d    = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            err_addr_d = '0;
        end else if (accept && enc_illegal) begin
            state_d    = S_FAULT;
            err_d      = 1'b1;
            err_addr_d = addr_q;
        end else if (accept) begin
            we_d       = 1'b1;
            waddr_d    = addr_q;
            wdata_d    = enc_word;
            addr_d     = addr_q + 1'b1;
            count_d    = count_q + 1'b1;
            state_d    = in_last ? S_DONE : ovf ? S_FAULT : S_RUN;
            done_d     = in_last;
            err_d      = ovf;
            err_addr_d = ovf ? addr_q : err_addr_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign im_we    = we_q;
    assign im_addr  = waddr_q;
    assign im_wdata = wdata_q;
    assign busy     = in_ready || we_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;
    assign count    = count_q;
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control decoder: turns instruction descriptors (class + fields) into 9-bit machine words.
- Writes the words sequentially into instruction memory through a registered write port.
- Sits between the boot/debug loader and the instruction RAM, so programs load without a host-side assembler.
- Owns address sequencing, illegal-encoding detection and end-of-program signalling.

Parameters:
- AW, 10, instruction memory address width.
- IW, 9, instruction word width (fixed; the encoding below assumes 9).

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin a load session at base_addr
- base_addr  in  AW  first write address
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- in_class  in  3  0 MOV, 1 B, 2 LI, 3 SHIFT, 4 MEM, 5 SBF, 6 ALU, 7 illegal
- in_dst  in  4  MOV dest; SHIFT/ALU uses [1:0]
- in_src  in  4  MOV src; MEM uses [2:0]
- in_imm  in  6  B/LI immediate; SHIFT uses [2:0] as amount
- in_sub  in  3  SHIFT [0]=dir(1=right); MEM [0]=store; SBF flag code; ALU op
- in_last  in  1  final descriptor of session
- im_we  out  1  instruction memory write strobe
- im_addr  out  AW  write address
- im_wdata  out  IW  encoded word
- busy  out  1  session active
- done  out  1  sticky; session ended normally
- err  out  1  sticky; illegal descriptor or address overflow
- err_addr  out  AW  address at which the error occurred
- count  out  AW+1  words written this session

Behaviour:
- Reset (async, Reset_n=0): state IDLE; all outputs 0; internal address register 0.
- FSM states: IDLE, RUN, DONE, FAULT.
- IDLE: on start, latch addr=base_addr, clear count/done/err/err_addr, go to RUN.
- RUN:
  - in_ready=1 only in RUN.
  - On accept, the word is encoded combinationally and registered.
  - Next cycle: im_we=1 with im_addr = address at accept and im_wdata = word.
  - addr increments and count increments at the accept edge. Latency is 1 cycle; sustains 1 word/cycle.
- Encoding:
  - MOV = {0, dst, src}
  - B = {100, imm}
  - LI = {101, imm}
  - SHIFT = {110, sub[0], dst[1:0], imm[2:0]}
  - MEM = {11110, sub[0], src[2:0]}
  - SBF = {111011, sub}
  - ALU = {1110, sub, dst[1:0]}
- Illegal descriptors:
  - class 7, SBF with sub>4, or ALU with sub>5.
  - Effect: no write; err=1, err_addr=current addr, go to FAULT.
- in_last accepted with a legal word: write proceeds as normal; done=1 in the same cycle as im_we; go to DONE.
- Overflow:
  - Accepting a word at addr = 2^AW-1 without in_last writes it, then goes to FAULT with err=1 and err_addr=2^AW-1.
  - No wrap-around write ever occurs.
- DONE/FAULT: in_ready=0; outputs hold. A start returns to RUN, clearing the sticky flags.
- start while in RUN is ignored. in_valid outside RUN is ignored.
- busy=1 in RUN and during the trailing write cycle.
- Reset mid-session aborts immediately. A pending registered write is dropped (im_we=0).

Decomposition:
- Shared package `isa_pkg`: instruction class enum, ALU sub-op codes (ADD 0, SUB 1, AND 2, OR 3, NOT 4, XOR 5), flag codes (NE 0, EQ 1, LT 2, LE 3, JP 4), opcode prefix constants, IW.
- Sub-module `instr_encoder`: purely combinational descriptor→{word, illegal}. It is shared with the testbench's checker. The top level holds the FSM, address and count registers, and the output register.

Test Plan:
- start base 0x010; MOV dst=9 src=3, then LI imm=0x2A with last → writes 0x093 @0x010 and 0x16A @0x011; done=1; count=2.
- ALU sub=1 dst=2, SHIFT dir=1 reg=1 amt=5, MEM store reg=6 (last) → 0x1C6, 0x1AD, 0x1EE at consecutive addresses, back-to-back one per cycle.
- SBF sub=6 at addr 0x020 → no im_we; err=1, err_addr=0x020; in_ready=0; next start clears err.
- base_addr 0x3FF; two descriptors, no last → one write @0x3FF; err=1, err_addr=0x3FF; second descriptor never accepted.
- Reset_n low for 1 cycle right after a RUN accept → im_we stays 0; all outputs 0 asynchronously; state IDLE.
- in_valid toggling randomly across 8 descriptors → write count and addresses exactly match accepts; no duplicate or missing words.
